patch_reducer_dispatcher: RTL and testbench
===========================================

Name: patch_reducer_dispatcher

Overview:
- Initiator and collector for a bank of N_PATCH_REDUCER patch-row reducers, all in the dram_clk domain.
- Accepts patch descriptors from the DRAM read path and assigns each one to the lowest-index free reducer with a one-cycle init pulse and a config word.
- Captures each reducer's one-cycle sum_rdy/sum result and returns results in round-robin order on a valid/ready stream tagged with patch_id.
- Frees a reducer only after its result has been popped.

Parameters:
- APP_DATA_WIDTH, 256, width of descriptor and reducer config word
- PATCH_SIZE, 6, weights per row (top and btm each)
- N_COL_SIZE, 12, column index width
- N_PATCH_REDUCER, 4, reducers managed (>=2)
- FP_SIZE, 16, weight/sum width
- PID_SIZE, 16, patch_id width

Ports:
- dram_clk  in  1  clock
- reset  in  1  synchronous, active-high
- cfg_valid  in  1  descriptor offered
- cfg_ready  out  1  descriptor accepted when cfg_valid&&cfg_ready
- cfg_topbtm  in  2  {do_top,do_btm}; 2'b00 is illegal
- cfg_data  in  APP_DATA_WIDTH  low bits {w5..w0 (FP_SIZE each, w5 MSB), start_col[N_COL_SIZE], patch_id[PID_SIZE]}
- red_init  out  2*N_PATCH_REDUCER  per-reducer 2-bit init (topbtm), one-cycle pulse
- red_config_data  out  APP_DATA_WIDTH  broadcast {w5..w0, start_col, owner_idx[log2(N_PATCH_REDUCER)]}, upper bits zero
- red_sum_rdy  in  2*N_PATCH_REDUCER  per-reducer 0=none, 1=single term, 2=top+btm
- red_sum  in  FP_SIZE*N_PATCH_REDUCER  per-reducer sum
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_patch_id  out  PID_SIZE  tag of result
- res_sum  out  FP_SIZE  captured sum
- res_nterm  out  2  captured sum_rdy code
- busy  out  N_PATCH_REDUCER  reducer-allocated bitmap
- err  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0, including busy, pending, red_init, red_config_data, res_* and err. Reset mid-operation drops all in-flight patches.
- cfg_ready = (busy != all-ones) && !reset. Purely combinational from registered state.
- Dispatch on accept at cycle T:
  - idx = lowest i with busy[i]==0.
  - At T+1: red_init[2*idx+:2]=cfg_topbtm, red_config_data = repacked word with owner_idx=idx, pid_tbl[idx]=patch_id, busy[idx]=1.
  - red_init returns to 0 at T+2. red_config_data holds until the next dispatch.
- Back-to-back accepts allowed every cycle. cfg_ready at T+1 already reflects the busy bit set at T.
- cfg_topbtm==0 on accept: descriptor is dropped (no init), err set, cfg_ready still asserted.
- Capture: red_sum_rdy[i]!=0 with busy[i]=1 and pending[i]=0 at cycle S → at S+1, hold_sum[i]=red_sum[i], hold_n[i]=code, pending[i]=1.
  - Reducer assertions of exactly one cycle must never be missed.
  - Multiple reducers in the same cycle are all captured.
- Capture on a non-busy or already-pending reducer is ignored and sets err.
- Output register: FSM OUT_EMPTY / OUT_FULL.
  - OUT_EMPTY: if any pending, the round-robin arbiter (priority starts after last granted index) picks j, loads res_*, clears pending[j], records cur=j, goes to OUT_FULL.
  - OUT_FULL: res_valid=1 and res_* stable until res_valid&&res_ready. On the pop cycle busy[cur] clears at the next edge. If another pending exists, reload in the same pop cycle (zero bubble) and stay FULL; else go to EMPTY.
- Latency: sum_rdy at S → res_valid earliest at S+2.
- Simultaneous pop of j and accept: the freed reducer is not eligible until the cycle after the pop. No same-cycle reuse.
- Simultaneous capture of i and arbiter grant: the new capture is visible to the arbiter next cycle.
- Reducer index never reused before its result is popped, so pid_tbl entries are stable while busy.

Decomposition:
- Package patch_reducer_pkg: field widths/offsets of the descriptor and config word (weight base, start_col, owner, patch_id), sum_rdy code constants, OUT_EMPTY/OUT_FULL encoding, log2 function.
- One sub-module: rr_arbiter (N-wide request, grant one-hot + index, advance on enable).

Test Plan:
- Single patch: after reset send descriptor pid=0x0011, topbtm=2'b11, start_col=5, w=1..6 → red_init[1:0]=2'b11 one cycle at T+1, red_config_data owner=0, busy=4'b0001. Drive red_sum_rdy[1:0]=2, red_sum[0]=0x0040 one cycle → res_valid with pid=0x0011, sum=0x0040, nterm=2. Pop → busy=0.
- Fill bank: 5 descriptors back-to-back with res_ready=0 → owners 0,1,2,3, busy=4'hF, cfg_ready=0 from the 5th offer until a pop. 5th descriptor goes to the freed index one cycle after the pop.
- Simultaneous completions: reducers 1,2,3 assert sum_rdy in the same cycle, res_ready=1 → three results on consecutive cycles in order 1,2,3 (rr after last grant 0), no bubble, busy clears for each.
- Backpressure: result held with res_ready=0 for 10 cycles → res_* stable. Reducer 2 completes meanwhile and is captured, then emitted after the pop.
- Errors: sum_rdy on non-busy reducer 3 → err=1, no result. Descriptor with topbtm=0 → no init, err stays 1.
- Reset with 2 busy and 1 pending → next cycle busy=0, res_valid=0, cfg_ready=1, err=0.

Source files
------------

// File: rtl/patch_reducer_pkg.sv
// patch_reducer_pkg: shared field layout, sum_rdy codes and output FSM encoding
package patch_reducer_pkg;
  localparam int PID_LSB = 0;
  localparam int OWNER_LSB = 0;
  localparam logic [1:0] SUM_NONE = 2'd0;
  localparam logic [1:0] SUM_SINGLE = 2'd1;
  localparam logic [1:0] SUM_PAIR = 2'd2;
  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_e;
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  function automatic int desc_col_lsb(input int pid_size);
    return PID_LSB + pid_size;
  endfunction
  function automatic int desc_w_lsb(input int pid_size, input int col_size);
    return PID_LSB + pid_size + col_size;
  endfunction
  function automatic int cfg_col_lsb(input int owner_size);
    return OWNER_LSB + owner_size;
  endfunction
  function automatic int cfg_w_lsb(input int owner_size, input int col_size);
    return OWNER_LSB + owner_size + col_size;
  endfunction
endpackage

// File: rtl/patch_reducer_dispatcher_rr_arbiter.sv
// rr_arbiter: round-robin pick, priority starting just after the last granted index
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic [W-1:0] last;
  int k;
  // first requester found scanning upward from last+1, wrapping
  always_comb begin
    gnt = '0;
    idx = '0;
    k = 0;
    for (int o = 1; o <= N; o++) begin
      k = (int'(last) + o) % N;
      if (req[k] && gnt == '0) begin
        gnt[k] = 1'b1;
        idx = W'(k);
      end
    end
  end
  // last starts at N-1 so index 0 has top priority after reset
  always_ff @(posedge clk) last <= rst ? W'(N - 1) : en ? idx : last;
endmodule

// File: rtl/patch_reducer_dispatcher.sv
// patch_reducer_dispatcher: allocates patch descriptors to reducers and returns their sums in round-robin order
module patch_reducer_dispatcher
  import patch_reducer_pkg::*;
#(
  parameter int APP_DATA_WIDTH = 256,
  parameter int PATCH_SIZE = 6,
  parameter int N_COL_SIZE = 12,
  parameter int N_PATCH_REDUCER = 4,
  parameter int FP_SIZE = 16,
  parameter int PID_SIZE = 16
) (
  input  logic                         dram_clk,
  input  logic                         reset,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [1:0]                   cfg_topbtm,
  input  logic [APP_DATA_WIDTH-1:0]    cfg_data,
  output logic [2*N_PATCH_REDUCER-1:0] red_init,
  output logic [APP_DATA_WIDTH-1:0]    red_config_data,
  input  logic [2*N_PATCH_REDUCER-1:0] red_sum_rdy,
  input  logic [FP_SIZE*N_PATCH_REDUCER-1:0] red_sum,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [PID_SIZE-1:0]          res_patch_id,
  output logic [FP_SIZE-1:0]           res_sum,
  output logic [1:0]                   res_nterm,
  output logic [N_PATCH_REDUCER-1:0]   busy,
  output logic                         err
);
  localparam int NP = N_PATCH_REDUCER;
  localparam int RW = 2 * NP;
  localparam int OW = log2(NP);
  localparam int WB = PATCH_SIZE * FP_SIZE;
  localparam int DCOL = desc_col_lsb(PID_SIZE);
  localparam int DW = desc_w_lsb(PID_SIZE, N_COL_SIZE);
  localparam int CCOL = cfg_col_lsb(OW);
  localparam int CW = cfg_w_lsb(OW, N_COL_SIZE);
  out_state_e state, state_n;
  logic [NP-1:0] pending, cap, bad, gnt;
  logic [OW-1:0] idx, gidx, cur;
  logic accept, dispatch, pop, load, found;
  logic [APP_DATA_WIDTH-1:0] cfg_word;
  logic [PID_SIZE-1:0] pid_tbl [NP];
  logic [FP_SIZE-1:0] hold_sum [NP];
  logic [1:0] hold_n [NP];
  logic unused_desc;
  assign unused_desc = ^cfg_data[APP_DATA_WIDTH-1:DW+WB];
  assign cfg_ready = ~&busy && !reset;
  assign accept = cfg_valid && cfg_ready;
  assign dispatch = accept && cfg_topbtm != 2'b00;
  assign res_valid = state == OUT_FULL;
  assign pop = res_valid && res_ready;
  // lowest free reducer and the repacked config word it will receive
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (!busy[i] && !found) begin
        idx = OW'(i);
        found = 1'b1;
      end
    end
    cfg_word = '0;
    cfg_word[OWNER_LSB+:OW] = idx;
    cfg_word[CCOL+:N_COL_SIZE] = cfg_data[DCOL+:N_COL_SIZE];
    cfg_word[CW+:WB] = cfg_data[DW+:WB];
  end
  // a sum is taken only from an allocated reducer with no result already waiting
  always_comb begin
    cap = '0;
    bad = '0;
    for (int i = 0; i < NP; i++) begin
      if (red_sum_rdy[2*i+:2] != SUM_NONE) begin
        cap[i] = busy[i] && !pending[i];
        bad[i] = !busy[i] || pending[i];
      end
    end
  end
  rr_arbiter #(.N(NP), .W(OW)) u_arb (
    .clk(dram_clk),
    .rst(reset),
    .req(pending),
    .en(load),
    .gnt(gnt),
    .idx(gidx)
  );
  // output register refills whenever it is empty or being popped
  always_comb begin
    state_n = state;
    load = 1'b0;
    if (state == OUT_EMPTY || pop) begin
      load = |pending;
      state_n = |pending ? OUT_FULL : OUT_EMPTY;
    end
  end
  // output FSM state register
  always_ff @(posedge dram_clk) state <= reset ? OUT_EMPTY : state_n;
  // allocation, capture and result registers
  always_ff @(posedge dram_clk) begin
    if (reset) begin
      busy <= '0;
      pending <= '0;
      red_init <= '0;
      red_config_data <= '0;
      res_patch_id <= '0;
      res_sum <= '0;
      res_nterm <= '0;
      cur <= '0;
      err <= 1'b0;
    end else begin
      busy <= (busy & ~(pop ? NP'(1) << cur : '0)) | (dispatch ? NP'(1) << idx : '0);
      pending <= (pending & ~(load ? gnt : '0)) | cap;
      red_init <= dispatch ? RW'(cfg_topbtm) << {idx, 1'b0} : '0;
      err <= err || |bad || (accept && cfg_topbtm == 2'b00);
      if (dispatch) begin
        red_config_data <= cfg_word;
        pid_tbl[idx] <= cfg_data[PID_LSB+:PID_SIZE];
      end
      if (load) begin
        res_patch_id <= pid_tbl[gidx];
        res_sum <= hold_sum[gidx];
        res_nterm <= hold_n[gidx];
        cur <= gidx;
      end
      for (int i = 0; i < NP; i++) begin
        if (cap[i]) begin
          hold_sum[i] <= red_sum[FP_SIZE*i+:FP_SIZE];
          hold_n[i] <= red_sum_rdy[2*i+:2];
        end
      end
    end
  end
endmodule

// File: tb/tb_patch_reducer_dispatcher.sv
// tb_patch_reducer_dispatcher: scoreboard bench for the reducer dispatcher
module tb_patch_reducer_dispatcher;
  logic dram_clk = 0, reset = 1, cfg_valid = 0, res_ready = 0;
  logic [1:0] cfg_topbtm = '0;
  logic [255:0] cfg_data = '0;
  logic [7:0] red_sum_rdy = '0;
  logic [63:0] red_sum = '0;
  logic cfg_ready, res_valid, err;
  logic [7:0] red_init;
  logic [255:0] red_config_data;
  logic [15:0] res_patch_id, res_sum;
  logic [1:0] res_nterm;
  logic [3:0] busy;
  typedef struct packed {logic [15:0] pid; logic [15:0] sum; logic [1:0] n;} res_t;
  res_t q[$];
  res_t e;
  int checks = 0, failures = 0;
  always #5 dram_clk = ~dram_clk;
  patch_reducer_dispatcher dut (
    .dram_clk(dram_clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_topbtm(cfg_topbtm), .cfg_data(cfg_data), .red_init(red_init),
    .red_config_data(red_config_data), .red_sum_rdy(red_sum_rdy), .red_sum(red_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_patch_id(res_patch_id),
    .res_sum(res_sum), .res_nterm(res_nterm), .busy(busy), .err(err)
  );
  task step;
    @(posedge dram_clk);
    #1;
  endtask
  function automatic logic [255:0] mk_desc(input logic [15:0] pid, input logic [11:0] col, input logic [15:0] wb);
    logic [255:0] d;
    d = '0;
    d[15:0] = pid;
    d[27:16] = col;
    for (int k = 0; k < 6; k++) d[28+16*k+:16] = wb + 16'(k + 1);
    return d;
  endfunction
  function automatic logic [255:0] mk_cfg(input logic [1:0] owner, input logic [11:0] col, input logic [15:0] wb);
    logic [255:0] c;
    c = '0;
    c[1:0] = owner;
    c[13:2] = col;
    for (int k = 0; k < 6; k++) c[14+16*k+:16] = wb + 16'(k + 1);
    return c;
  endfunction
  task offer(input logic [15:0] pid, input logic [1:0] tb, input logic [11:0] col, input logic [15:0] wb);
    cfg_valid = 1;
    cfg_topbtm = tb;
    cfg_data = mk_desc(pid, col, wb);
  endtask
  task lane(input int i, input logic [1:0] c, input logic [15:0] s);
    red_sum_rdy[2*i+:2] = c;
    red_sum[16*i+:16] = s;
  endtask
  task test_reset;
    reset = 1;
    step;
    step;
    checks++;
    if (cfg_ready !== 1'b0) begin failures++; $display("FAIL reset_cfg_ready_low: got %b want 0", cfg_ready); end
    reset = 0;
    #1;
    checks++;
    if ({busy, res_valid, red_init, err, cfg_ready} !== {4'b0, 1'b0, 8'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL reset_ctrl: got busy=%b v=%b init=%h err=%b rdy=%b want 0 0 00 0 1", busy, res_valid, red_init, err, cfg_ready);
    end
    checks++;
    if ({red_config_data, res_patch_id, res_sum, res_nterm} !== '0) begin
      failures++; $display("FAIL reset_data: got cfg=%h pid=%h sum=%h n=%0d want zeros", red_config_data, res_patch_id, res_sum, res_nterm);
    end
  endtask
  task test_single;
    offer(16'h0011, 2'b11, 12'd5, 16'd0);
    checks++;
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b want 1", cfg_ready); end
    step;
    cfg_valid = 0;
    checks++;
    if (red_init !== 8'h03 || red_config_data !== mk_cfg(2'd0, 12'd5, 16'd0) || busy !== 4'b0001) begin
      failures++; $display("FAIL single_dispatch: got init=%h cfg=%h busy=%b want 03 %h 0001", red_init, red_config_data, busy, mk_cfg(2'd0, 12'd5, 16'd0));
    end
    step;
    checks++;
    if (red_init !== 8'h00) begin failures++; $display("FAIL single_init_pulse: got %h want 00", red_init); end
    lane(0, 2'd2, 16'h0040);
    q.push_back('{16'h0011, 16'h0040, 2'd2});
    step;
    red_sum_rdy = '0;
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL single_latency_early: got %b want 0", res_valid); end
    step;
    checks++;
    if (res_valid !== 1'b1) begin failures++; $display("FAIL single_latency: got %b want 1", res_valid); end
    e = q.pop_front();
    checks++;
    if ({res_patch_id, res_sum, res_nterm} !== e) begin failures++; $display("FAIL single_result: got %h want %h", {res_patch_id, res_sum, res_nterm}, e); end
    res_ready = 1;
    step;
    res_ready = 0;
    checks++;
    if (busy !== 4'b0000 || res_valid !== 1'b0) begin failures++; $display("FAIL single_free: got busy=%b v=%b want 0000 0", busy, res_valid); end
  endtask
  task test_fill;
    logic [7:0] ei;
    for (int k = 0; k < 4; k++) begin
      offer(16'h0100 + 16'(k), 2'(k % 3 + 1), 12'(k), 16'(16 * k));
      checks++;
      if (cfg_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_%0d: got %b want 1", k, cfg_ready); end
      step;
      ei = 8'(k % 3 + 1) << (2 * k);
      checks++;
      if (red_init !== ei || red_config_data !== mk_cfg(2'(k), 12'(k), 16'(16 * k)) || busy !== 4'((1 << (k + 1)) - 1)) begin
        failures++; $display("FAIL fill_dispatch_%0d: got init=%h cfg=%h busy=%b want %h %h %b", k, red_init, red_config_data, busy, ei, mk_cfg(2'(k), 12'(k), 16'(16 * k)), 4'((1 << (k + 1)) - 1));
      end
    end
    offer(16'h0104, 2'b10, 12'd9, 16'h0050);
    checks++;
    if (cfg_ready !== 1'b0) begin failures++; $display("FAIL fill_full_ready: got %b want 0", cfg_ready); end
    step;
    checks++;
    if (red_init !== 8'h00 || busy !== 4'hF) begin failures++; $display("FAIL fill_stall: got init=%h busy=%b want 00 1111", red_init, busy); end
    lane(1, 2'd1, 16'h1234);
    q.push_back('{16'h0101, 16'h1234, 2'd1});
    step;
    red_sum_rdy = '0;
    for (int n = 0; n < 10 && !res_valid; n++) step;
    checks++;
    if (res_valid !== 1'b1) begin failures++; $display("FAIL fill_result_timeout: got %b want 1", res_valid); end
    e = q.pop_front();
    checks++;
    if ({res_patch_id, res_sum, res_nterm} !== e || cfg_ready !== 1'b0) begin
      failures++; $display("FAIL fill_result: got %h rdy=%b want %h rdy=0", {res_patch_id, res_sum, res_nterm}, cfg_ready, e);
    end
    res_ready = 1;
    step;
    res_ready = 0;
    checks++;
    if (busy !== 4'b1101 || cfg_ready !== 1'b1 || red_init !== 8'h00) begin
      failures++; $display("FAIL fill_after_pop: got busy=%b rdy=%b init=%h want 1101 1 00", busy, cfg_ready, red_init);
    end
    step;
    cfg_valid = 0;
    checks++;
    if (red_init !== 8'h08 || red_config_data !== mk_cfg(2'd1, 12'd9, 16'h0050) || busy !== 4'hF) begin
      failures++; $display("FAIL fill_reuse: got init=%h cfg=%h busy=%b want 08 %h 1111", red_init, red_config_data, busy, mk_cfg(2'd1, 12'd9, 16'h0050));
    end
  endtask
  task test_simultaneous;
    lane(0, 2'd2, 16'h0a0a);
    q.push_back('{16'h0100, 16'h0a0a, 2'd2});
    step;
    red_sum_rdy = '0;
    for (int n = 0; n < 10 && !res_valid; n++) step;
    e = q.pop_front();
    checks++;
    if (res_valid !== 1'b1 || {res_patch_id, res_sum, res_nterm} !== e) begin
      failures++; $display("FAIL simul_first: got v=%b %h want 1 %h", res_valid, {res_patch_id, res_sum, res_nterm}, e);
    end
    res_ready = 1;
    step;
    res_ready = 0;
    lane(1, 2'd1, 16'h1111);
    lane(2, 2'd2, 16'h2222);
    lane(3, 2'd1, 16'h3333);
    q.push_back('{16'h0104, 16'h1111, 2'd1});
    q.push_back('{16'h0102, 16'h2222, 2'd2});
    q.push_back('{16'h0103, 16'h3333, 2'd1});
    step;
    red_sum_rdy = '0;
    res_ready = 1;
    for (int n = 0; n < 10 && !res_valid; n++) step;
    for (int k = 0; k < 3; k++) begin
      e = q.pop_front();
      checks++;
      if (res_valid !== 1'b1 || {res_patch_id, res_sum, res_nterm} !== e || busy !== 4'(4'b1110 << k)) begin
        failures++; $display("FAIL simul_result_%0d: got v=%b %h busy=%b want 1 %h %b", k, res_valid, {res_patch_id, res_sum, res_nterm}, busy, e, 4'(4'b1110 << k));
      end
      step;
    end
    res_ready = 0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 4'b0000) begin failures++; $display("FAIL simul_drain: got v=%b busy=%b want 0 0000", res_valid, busy); end
  endtask
  task test_backpressure;
    for (int k = 0; k < 3; k++) begin
      offer(16'h0200 + 16'(k), 2'b11, 12'(20 + k), 16'(3 * k));
      step;
    end
    cfg_valid = 0;
    checks++;
    if (busy !== 4'b0111) begin failures++; $display("FAIL bp_busy: got %b want 0111", busy); end
    lane(0, 2'd1, 16'hAAAA);
    q.push_back('{16'h0200, 16'hAAAA, 2'd1});
    step;
    red_sum_rdy = '0;
    for (int n = 0; n < 10 && !res_valid; n++) step;
    e = q[0];
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (res_valid !== 1'b1 || {res_patch_id, res_sum, res_nterm} !== e) begin
        failures++; $display("FAIL bp_hold_%0d: got v=%b %h want 1 %h", k, res_valid, {res_patch_id, res_sum, res_nterm}, e);
      end
      if (k == 3) begin
        lane(2, 2'd2, 16'hBBBB);
        q.push_back('{16'h0202, 16'hBBBB, 2'd2});
      end
      step;
      red_sum_rdy = '0;
    end
    void'(q.pop_front());
    res_ready = 1;
    step;
    e = q.pop_front();
    checks++;
    if (res_valid !== 1'b1 || {res_patch_id, res_sum, res_nterm} !== e || busy !== 4'b0110) begin
      failures++; $display("FAIL bp_reload: got v=%b %h busy=%b want 1 %h 0110", res_valid, {res_patch_id, res_sum, res_nterm}, busy, e);
    end
    step;
    res_ready = 0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 4'b0010) begin failures++; $display("FAIL bp_done: got v=%b busy=%b want 0 0010", res_valid, busy); end
  endtask
  task test_errors;
    logic seen;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_clean: got %b want 0", err); end
    lane(3, 2'd2, 16'h5555);
    step;
    red_sum_rdy = '0;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_idle_sum: got %b want 1", err); end
    seen = 0;
    for (int n = 0; n < 4; n++) begin
      seen = seen | res_valid;
      step;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL err_no_result: got %b want 0", seen); end
    offer(16'h0300, 2'b00, 12'd1, 16'd0);
    checks++;
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL err_ready: got %b want 1", cfg_ready); end
    step;
    cfg_valid = 0;
    checks++;
    if (red_init !== 8'h00 || busy !== 4'b0010 || err !== 1'b1 || red_config_data !== mk_cfg(2'd2, 12'd22, 16'd6)) begin
      failures++; $display("FAIL err_drop: got init=%h busy=%b err=%b cfg=%h want 00 0010 1 %h", red_init, busy, err, red_config_data, mk_cfg(2'd2, 12'd22, 16'd6));
    end
  endtask
  task test_reset_mid;
    offer(16'h0400, 2'b01, 12'd3, 16'd7);
    step;
    cfg_valid = 0;
    lane(1, 2'd2, 16'h0101);
    step;
    red_sum_rdy = '0;
    for (int n = 0; n < 10 && !res_valid; n++) step;
    lane(0, 2'd1, 16'h0202);
    step;
    red_sum_rdy = '0;
    checks++;
    if (busy !== 4'b0011 || res_valid !== 1'b1) begin failures++; $display("FAIL rst_setup: got busy=%b v=%b want 0011 1", busy, res_valid); end
    reset = 1;
    step;
    reset = 0;
    #1;
    q.delete();
    checks++;
    if (busy !== 4'b0000 || res_valid !== 1'b0 || cfg_ready !== 1'b1 || err !== 1'b0 || red_init !== 8'h00) begin
      failures++; $display("FAIL rst_mid: got busy=%b v=%b rdy=%b err=%b init=%h want 0000 0 1 0 00", busy, res_valid, cfg_ready, err, red_init);
    end
    step;
    step;
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_pending_dropped: got %b want 0", res_valid); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_fill;
    test_simultaneous;
    test_backpressure;
    test_errors;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
